// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed response latency.
//
// A request is accepted in IDLE, held for LATENCY clock edges, then answered
// from (or written into) the word-addressed array main_memory. Out-of-range
// addresses return resp_err=1 with zero data and never touch the array.
// The response is held in RESP until the consumer raises resp_ready.
//
// Build option: define MEM_RESPONDER_STATS_EN to enable the rd_count/wr_count
// completion counters; without it both ports are tied to zero.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   word address and write data
//   resp_valid/resp_ready response handshake (valid only in RESP)
//   resp_rdata, resp_err  read data (or echoed write data) and range error
//   rd_count, wr_count    completed error-free read / write responses
//
// State | meaning
// IDLE  | waiting for a request, req_ready=1
// WAIT  | request latched, latency counter running down
// RESP  | response presented, waiting for resp_ready
module mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Depth widened by one bit so the range compare never truncates MEM_DEPTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]            lat_cnt;
    logic [7:0]            lat_cnt_next;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  accept;
    logic                  fire;
    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;

    logic [DATA_WIDTH-1:0] main_memory [MEM_DEPTH];

    assign in_range = ({1'b0, lat_addr} < DEPTH_EXT);
    assign mem_idx  = lat_addr[IDX_W-1:0];

    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        accept       = 1'b0;
        fire         = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept       = 1'b1;
                    lat_cnt_next = LAT_LOAD;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 8'd0) begin
                    fire       = 1'b1;
                    state_next = RESP;
                end else begin
                    lat_cnt_next = lat_cnt - 8'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= 8'd0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            // Response data is captured once, on entry to RESP, and then held.
            if (fire) begin
                resp_err <= ~in_range;
                if (!in_range) begin
                    resp_rdata <= '0;
                end else if (lat_write) begin
                    resp_rdata <= lat_wdata;
                end else begin
                    resp_rdata <= main_memory[mem_idx];
                end
            end
        end
    end

    // Array has no reset; a reset at the firing edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && fire && lat_write && in_range) begin
            main_memory[mem_idx] <= lat_wdata;
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    logic complete;

    assign complete = (state == RESP) && resp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (complete && !resp_err) begin
            if (lat_write) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized traffic,
// checked against a word-array reference model. A second instance with
// LATENCY=1 is exercised with back-to-back requests.
module tb_mem_responder;

    localparam int LAT = 3;

`ifdef MEM_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    logic        req_valid1;
    logic        req_ready1;
    logic        req_write1;
    logic [15:0] req_addr1;
    logic [15:0] req_wdata1;
    logic        resp_valid1;
    logic        resp_ready1;
    logic [15:0] resp_rdata1;
    logic        resp_err1;
    logic [31:0] rd_count1;
    logic [31:0] wr_count1;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] model_mem [1024];
    logic [15:0] l1_mem [1024];
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;

    mem_responder #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    mem_responder #(.LATENCY(1)) dut_l1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_write  (req_write1),
        .req_addr   (req_addr1),
        .req_wdata  (req_wdata1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_rdata (resp_rdata1),
        .resp_err   (resp_err1),
        .rd_count   (rd_count1),
        .wr_count   (wr_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on the LATENCY=3 instance, starting and ending
    // at a sample point with the responder idle.
    task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int hold);
        logic [15:0] exp_d;
        logic        exp_e;
        exp_e = (addr >= 16'd1024);
        if (exp_e)
            exp_d = 16'h0000;
        else if (wr)
            exp_d = wd;
        else
            exp_d = model_mem[addr[9:0]];

        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'($urandom);
        tick();
        if (wr && !exp_e)
            model_mem[addr[9:0]] = wd;

        // Latency window: nothing visible, and stray request traffic ignored.
        for (int k = 0; k < LAT; k++) begin
            chk("wait_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_addr   = 16'($urandom);
            req_wdata  = 16'($urandom);
            resp_ready = 1'($urandom);
            tick();
        end

        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, exp_d});
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_e});
        chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rd_count_pre", rd_count, exp_rd);
        chk("wr_count_pre", wr_count, exp_wr);

        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            tick();
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", {16'd0, resp_rdata}, {16'd0, exp_d});
            chk("hold_err", {31'd0, resp_err}, {31'd0, exp_e});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end

        resp_ready = 1'b1;
        tick();
        if (STATS && !exp_e) begin
            if (wr) exp_wr = exp_wr + 32'd1;
            else    exp_rd = exp_rd + 32'd1;
        end
        chk("done_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("done_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rd_count", rd_count, exp_rd);
        chk("wr_count", wr_count, exp_wr);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic        wr;
        logic [15:0] addr;
        logic [15:0] exp_a;
        logic [31:0] exp_rd1;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        req_valid1 = 1'b0;
        req_write1 = 1'b0;
        req_addr1  = '0;
        req_wdata1 = '0;
        resp_ready1 = 1'b0;
        exp_rd = 32'd0;
        exp_wr = 32'd0;

        for (int i = 0; i < 1024; i++) begin
            model_mem[i] = 16'($urandom);
        end
        model_mem[16'h0010] = 16'hAAAA;
        model_mem[16'h0020] = 16'hBBBB;
        for (int i = 0; i < 1024; i++) begin
            l1_mem[i] = model_mem[i];
            dut.main_memory[i] = model_mem[i];
            dut_l1.main_memory[i] = model_mem[i];
        end

        tick();
        tick();
        reset = 1'b0;

        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rdata", {16'd0, resp_rdata}, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rd_count", rd_count, 32'd0);
        chk("rst_wr_count", wr_count, 32'd0);

        // Basic read, write-then-read, out-of-range, and held response.
        xact(1'b0, 16'h0010, 16'h0000, 0);
        xact(1'b1, 16'h0030, 16'hCCCC, 0);
        xact(1'b0, 16'h0030, 16'h0000, 0);
        xact(1'b0, 16'h0400, 16'h0000, 0);
        xact(1'b1, 16'h0400, 16'h5A5A, 1);
        xact(1'b0, 16'h0000, 16'h0000, 0);
        xact(1'b0, 16'h0010, 16'h0000, 5);

        // Reset one edge after accepting a write: the write must not land.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'h1234;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rd = 32'd0;
        exp_wr = 32'd0;
        chk("wrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("wrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("wrst_rdata", {16'd0, resp_rdata}, 32'd0);
        chk("wrst_wr_count", wr_count, 32'd0);
        xact(1'b0, 16'h0020, 16'h0000, 0);
        xact(1'b1, 16'h0044, 16'h7777, 2);

        // Reset in RESP together with resp_ready and a new request.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < LAT; k++) tick();
        chk("rrst_pre_valid", {31'd0, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 16'h0030;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        exp_rd = 32'd0;
        exp_wr = 32'd0;
        chk("rrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rrst_rd_count", rd_count, 32'd0);
        chk("rrst_rdata", {16'd0, resp_rdata}, 32'd0);
        tick();
        chk("rrst_req_ready", {31'd0, req_ready}, 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                addr = 16'($urandom_range(1024, 65535));
            else
                addr = 16'($urandom_range(0, 1023));
            xact(wr, addr, 16'($urandom), int'($urandom_range(0, 3)));
        end

        // LATENCY=1 instance, request and resp_ready held high: the pattern
        // repeats accept / respond / complete every three edges.
        exp_rd1     = 32'd0;
        exp_a       = '0;
        req_valid1  = 1'b1;
        resp_ready1 = 1'b1;
        req_write1  = 1'b0;
        req_addr1   = 16'($urandom_range(0, 1023));
        for (int k = 0; k < 12; k++) begin
            case (k % 3)
                0: begin
                    chk("l1_idle_ready", {31'd0, req_ready1}, 32'd1);
                    chk("l1_idle_valid", {31'd0, resp_valid1}, 32'd0);
                    exp_a = req_addr1;
                end
                1: begin
                    chk("l1_wait_ready", {31'd0, req_ready1}, 32'd0);
                    chk("l1_wait_valid", {31'd0, resp_valid1}, 32'd0);
                    req_addr1 = 16'($urandom_range(0, 1023));
                end
                default: begin
                    chk("l1_resp_ready", {31'd0, req_ready1}, 32'd0);
                    chk("l1_resp_valid", {31'd0, resp_valid1}, 32'd1);
                    chk("l1_resp_rdata", {16'd0, resp_rdata1}, {16'd0, l1_mem[exp_a[9:0]]});
                    if (STATS) exp_rd1 = exp_rd1 + 32'd1;
                end
            endcase
            tick();
        end
        req_valid1  = 1'b0;
        resp_ready1 = 1'b0;
        chk("l1_rd_count", rd_count1, exp_rd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, request address width in bits.
REQ-002 Parameter DATA_WIDTH, default 16, data word width in bits.
REQ-003 Parameter MEM_DEPTH, default 1024, number of words in the backing array `main_memory`; word addressed.
REQ-004 Parameter LATENCY, default 3, clock edges from request acceptance to response; legal range 1..255.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 req_valid  input  1  cache presents a request.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  word address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  cache consumes the response.
REQ-014 resp_rdata  output  DATA_WIDTH  read data, or echoed write data for writes.
REQ-015 resp_err  output  1  request address was out of range.
REQ-016 rd_count  output  32  completed read responses.
REQ-017 wr_count  output  32  completed write responses.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-019 req_ready SHALL be 1 in IDLE only; resp_valid SHALL be 1 in RESP only.
REQ-020 Acceptance (req_valid && req_ready at an edge) SHALL latch req_write, req_addr and req_wdata, load the latency counter with LATENCY-1, and move to WAIT.
REQ-021 In WAIT, a counter value of 0 SHALL move to RESP; otherwise the counter SHALL decrement.
REQ-022 resp_valid SHALL first be visible after edge E0+LATENCY, where E0 is the acceptance edge.
REQ-023 On the WAIT->RESP edge, a latched read SHALL capture main_memory[addr] into resp_rdata.
REQ-024 On the WAIT->RESP edge, a latched write SHALL store wdata into main_memory[addr] and set resp_rdata to wdata.
REQ-025 An address >= MEM_DEPTH SHALL set resp_err=1 and resp_rdata=0, with no memory access; otherwise resp_err=0.
REQ-026 resp_rdata, resp_err and the response type SHALL remain stable throughout RESP.
REQ-027 In RESP, resp_ready=1 at an edge SHALL complete the response and move to IDLE; resp_ready=0 SHALL keep the FSM in RESP indefinitely.
REQ-028 No new request SHALL be accepted in the cycle of the completion edge; the earliest next acceptance is the following edge, so at most one request is in flight.
REQ-029 req_* inputs SHALL be ignored outside IDLE.
REQ-030 main_memory SHALL NOT be reset; a test bench preloads it hierarchically.

Reset
REQ-031 When reset=1 at an edge, the block SHALL return to IDLE with resp_valid=0, req_ready=1 from the next cycle, resp_rdata=0, resp_err=0, latency counter=0, rd_count=0 and wr_count=0.
REQ-032 Reset during WAIT SHALL discard the pending request, and a pending write SHALL NOT modify main_memory.
REQ-033 Reset during RESP SHALL drop the response without counting it.
REQ-034 Reset SHALL take priority over every other event at the same edge.

Configuration
REQ-035 With macro MEM_RESPONDER_STATS_EN defined, each completed response with resp_err=0 SHALL increment rd_count or wr_count (according to its type) by 1, wrapping from 2^32-1 to 0.
REQ-036 Without MEM_RESPONDER_STATS_EN, rd_count and wr_count SHALL be constant 0, with the ports still present.

Verification
REQ-037 Preload main_memory[16'h0010]=16'hAAAA; read 16'h0010 with resp_ready=1 -> resp_valid high 3 edges after acceptance, resp_rdata=16'hAAAA, resp_err=0, rd_count=1 (stats on).
REQ-038 Write 16'h0030 with 16'hCCCC, then read 16'h0030 -> write response resp_rdata=16'hCCCC, then read response resp_rdata=16'hCCCC, wr_count=1, rd_count=1.
REQ-039 Read 16'h0400 (=1024) -> resp_err=1, resp_rdata=16'h0000, counters unchanged, main_memory untouched.
REQ-040 Read with resp_ready held 0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stable for those 5 cycles; req_ready=0 throughout; completion on the first resp_ready=1 edge.
REQ-041 Write 16'h0020 with 16'h1234, reset asserted 1 edge after acceptance -> req_ready=1 and resp_valid=0 after reset; a subsequent read of 16'h0020 returns the preloaded 16'hBBBB; wr_count=0.
REQ-042 LATENCY=1 with back-to-back req_valid and resp_ready=1 -> responses on alternate-plus-one edges (accept, respond, complete, accept), never two requests in flight.
